bcd_serial_addsub: RTL

//  Digit-serial BCD add/subtract controller for multi-digit decimal operands.

---
 rtl/bcd_serial_addsub.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one shared digit adder with a nine's-complement
// stage on y, sequenced least-significant digit first.
module bcd_serial_addsub #(
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic [4*DIGITS-1:0] x,
    input  logic [4*DIGITS-1:0] y,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] z,
    output logic                co,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  y_q, y_d;
    logic [W-1:0]  z_q, z_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          op_q, op_d;
    logic          carry_q, carry_d;
    logic          co_q, co_d;
    logic          err_q, err_d;

    logic [3:0]    xd, yd, bd, zd;
    logic [4:0]    sum;
    logic          cout;
    logic          last;

    // Digit datapath: select current digit, nine's-complement y when subtracting
    always_comb begin
        xd = '0;
        yd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                xd = x_q[4*i +: 4];
                yd = y_q[4*i +: 4];
            end
        end
        bd   = op_q ? (4'd9 - yd) : yd;
        sum  = {1'b0, xd} + {1'b0, bd} + {4'b0, carry_q};
        cout = (sum > 5'd9);
        zd   = cout ? (sum[3:0] + 4'd6) : sum[3:0];
        last = (idx_q == IW'(DIGITS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        z_d     = z_q;
        co_d    = co_q;
        err_d   = err_q;
        if (state_q == IDLE && start) begin
            x_d     = x;
            y_d     = y;
            op_d    = op;
            carry_d = op;
            idx_d   = '0;
            z_d     = '0;
            err_d   = 1'b0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == IW'(i)) z_d[4*i +: 4] = zd;
            end
            carry_d = cout;
            err_d   = err_q | (xd > 4'd9) | (yd > 4'd9);
            if (last) begin
                co_d = cout;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            z_q     <= '0;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            z_q     <= z_d;
            co_q    <= co_d;
            err_q   <= err_d;
        end
    end

    assign z   = z_q;
    assign co  = co_q;
    assign err = err_q;

endmodule
